// File: rtl/iq_stream_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : iq_stream_scheduler
//  Description : Frame ring-buffer bookkeeping for an external I/Q sample RAM
//                plus the read-out sequencer.
//                The write side advances the head pointer on every incoming
//                frame. The read side loads a frame into the hold register and
//                then steps through its bytes one host strobe at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module iq_stream_scheduler #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk_in,
    input  logic          reset_n,
    input  logic          iq_valid,
    input  logic          rx2_enable,
    input  logic          stream_start,
    input  logic          stream_stop,
    input  logic          byte_strobe,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic          frame_load,
    output logic [1:0]    word_sel,
    output logic [1:0]    byte_sel,
    output logic [AW:0]   fill_level,
    output logic [15:0]   overflow_cnt,
    output logic          underrun,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_LATCH = 2'd2,
        S_SEND  = 2'd3
    } state_t;

    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [15:0]   ovf_q, ovf_d;
    logic          underrun_q, underrun_d;
    logic [1:0]    word_sel_q, word_sel_d;
    logic [1:0]    byte_sel_q, byte_sel_d;
    logic [1:0]    last_word_q, last_word_d;

    logic          w_consume;
    logic          w_drop;

    // Ring-buffer pointers, fill accounting and overflow counting
    always_comb begin
        w_consume = (state_q == S_LOAD) && (fill_q != '0);
        // A full buffer only drops when the same cycle is not also reading
        // the oldest slot; a coincident read frees the slot being written.
        w_drop    = iq_valid && (fill_q == C_FULL) && !w_consume;

        head_d    = iq_valid ? head_q + AW'(1) : head_q;
        tail_d    = (w_consume || w_drop) ? tail_q + AW'(1) : tail_q;
        rd_addr_d = w_consume ? tail_q : rd_addr_q;

        fill_d = fill_q;
        if ((iq_valid && !w_drop) && !w_consume) begin
            fill_d = fill_q + (AW+1)'(1);
        end else if (!iq_valid && w_consume) begin
            fill_d = fill_q - (AW+1)'(1);
        end

        ovf_d = ovf_q;
        if (w_drop && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    // Read-out sequencer: next state, selectors, underrun flag
    always_comb begin
        state_d     = state_q;
        word_sel_d  = word_sel_q;
        byte_sel_d  = byte_sel_q;
        last_word_d = last_word_q;
        underrun_d  = underrun_q;

        // Frame-level bookkeeping happens in LOAD irrespective of any
        // host command arriving in the same cycle.
        if (state_q == S_LOAD) begin
            last_word_d = rx2_enable ? 2'd3 : 2'd1;
            if (!w_consume) begin
                underrun_d = 1'b1;
            end
        end

        if (stream_start) begin
            state_d    = S_LOAD;
            underrun_d = 1'b0;
        end else if (stream_stop) begin
            state_d    = S_IDLE;
            word_sel_d = 2'd0;
            byte_sel_d = 2'd0;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_LOAD:  state_d = S_LATCH;
                S_LATCH: begin
                    word_sel_d = 2'd0;
                    byte_sel_d = 2'd0;
                    state_d    = S_SEND;
                end
                S_SEND: begin
                    if (byte_strobe) begin
                        if (byte_sel_q == 2'd3) begin
                            byte_sel_d = 2'd0;
                            word_sel_d = word_sel_q + 2'd1;
                            if (word_sel_q == last_word_q) begin
                                state_d = S_LOAD;
                            end
                        end else begin
                            byte_sel_d = byte_sel_q + 2'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            rd_addr_q   <= '0;
            fill_q      <= '0;
            ovf_q       <= '0;
            underrun_q  <= 1'b0;
            word_sel_q  <= 2'd0;
            byte_sel_q  <= 2'd0;
            last_word_q <= 2'd1;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            rd_addr_q   <= rd_addr_d;
            fill_q      <= fill_d;
            ovf_q       <= ovf_d;
            underrun_q  <= underrun_d;
            word_sel_q  <= word_sel_d;
            byte_sel_q  <= byte_sel_d;
            last_word_q <= last_word_d;
        end
    end

    assign wr_en        = iq_valid;
    assign wr_addr      = head_q;
    assign rd_addr      = rd_addr_q;
    assign frame_load   = (state_q == S_LATCH);
    assign word_sel     = word_sel_q;
    assign byte_sel     = byte_sel_q;
    assign fill_level   = fill_q;
    assign overflow_cnt = ovf_q;
    assign underrun     = underrun_q;
    assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_iq_stream_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iq_stream_scheduler
//  Description : Self-checking bench for iq_stream_scheduler. A queue-based
//                reference model of the frame buffer and a byte-index model
//                of the read-out predict every output each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_iq_stream_scheduler;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk_in = 1'b0;
    logic          reset_n;
    logic          iq_valid, rx2_enable, stream_start, stream_stop, byte_strobe;
    logic          wr_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          frame_load;
    logic [1:0]    word_sel, byte_sel;
    logic [AW:0]   fill_level;
    logic [15:0]   overflow_cnt;
    logic          underrun, busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase 0=IDLE 1=LOAD 2=LATCH 3=SEND
    int m_ph, m_head, m_rd, m_ovf, m_und, m_k, m_nb;
    int m_q[$];

    iq_stream_scheduler #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .iq_valid     (iq_valid),
        .rx2_enable   (rx2_enable),
        .stream_start (stream_start),
        .stream_stop  (stream_stop),
        .byte_strobe  (byte_strobe),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .frame_load   (frame_load),
        .word_sel     (word_sel),
        .byte_sel     (byte_sel),
        .fill_level   (fill_level),
        .overflow_cnt (overflow_cnt),
        .underrun     (underrun),
        .busy         (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_head = 0; m_rd = 0; m_ovf = 0; m_und = 0; m_k = 0; m_nb = 8;
        m_q.delete();
    endtask

    task automatic check_outputs();
        chk("wr_en",        32'(wr_en),        32'(iq_valid));
        chk("wr_addr",      32'(wr_addr),      32'(m_head));
        chk("rd_addr",      32'(rd_addr),      32'(m_rd));
        chk("frame_load",   32'(frame_load),   32'(m_ph == 2));
        chk("word_sel",     32'(word_sel),     32'((m_k / 4) % 4));
        chk("byte_sel",     32'(byte_sel),     32'(m_k % 4));
        chk("fill_level",   32'(fill_level),   32'(m_q.size()));
        chk("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
        chk("underrun",     32'(underrun),     32'(m_und));
        chk("busy",         32'(busy),         32'(m_ph != 0));
    endtask

    task automatic model_step(input logic v, input logic rx2, input logic st,
                              input logic sp, input logic bs);
        bit cons;
        int tmp;
        cons = (m_ph == 1) && (m_q.size() > 0);
        if (m_ph == 1) begin
            if (cons) m_rd = m_q.pop_front();
            else      m_und = 1;
            m_nb = rx2 ? 16 : 8;
        end
        if (v) begin
            if (m_q.size() == DEPTH) begin
                tmp = m_q.pop_front();
                if (m_ovf < 65535) m_ovf++;
            end
            m_q.push_back(m_head);
            m_head = (m_head + 1) % DEPTH;
        end
        if (st) begin
            m_ph = 1; m_und = 0;
        end else if (sp) begin
            m_ph = 0; m_k = 0;
        end else begin
            case (m_ph)
                1: m_ph = 2;
                2: begin m_ph = 3; m_k = 0; end
                3: if (bs) begin
                       if (m_k == m_nb - 1) m_ph = 1;
                       m_k = (m_k + 1) % 16;
                   end
                default: ;
            endcase
        end
    endtask

    // One clock: drive, check against model, advance model, cross edge
    task automatic cyc(input logic v, input logic rx2, input logic st,
                       input logic sp, input logic bs);
        iq_valid = v; rx2_enable = rx2; stream_start = st;
        stream_stop = sp; byte_strobe = bs;
        #1;
        check_outputs();
        model_step(v, rx2, st, sp, bs);
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        model_reset();
        check_outputs();
        @(posedge clk_in);
        #1;
        check_outputs();
        reset_n = 1'b1;
    endtask

    initial begin
        iq_valid = 0; rx2_enable = 0; stream_start = 0; stream_stop = 0; byte_strobe = 0;
        reset_n = 1'b1;
        model_reset();
        @(posedge clk_in); #1;
        do_reset();

        // Three frames, RX1 only, full eight-byte read-out
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("first_rd_addr", 32'(rd_addr), 32'd0);
        chk("latch_pulse", 32'(frame_load), 32'd1);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("fill_after_2nd_load", 32'(fill_level), 32'd1);

        // RX2 frame: sixteen bytes
        do_reset();
        cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 1);
        chk("rx2_back_to_load", 32'(busy && !frame_load && (word_sel == 2'd0)), 32'd1);
        cyc(0, 0, 0, 0, 0);
        chk("empty_underrun", 32'(underrun), 32'd1);
        cyc(0, 0, 1, 0, 0);
        chk("start_clears_underrun", 32'(underrun), 32'd0);

        // Overflow: ten frames into eight slots, then coincident write/read
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0);
        chk("fill_full", 32'(fill_level), 32'd8);
        chk("ovf_two", 32'(overflow_cnt), 32'd2);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rd_after_ovf", 32'(rd_addr), 32'd2);
        chk("fill_coincident", 32'(fill_level), 32'd8);
        chk("ovf_coincident", 32'(overflow_cnt), 32'd2);

        // Stop at byte 5, restart, then reset mid-SEND
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        chk("stop_idle", 32'(busy), 32'd0);
        chk("stop_bytesel", 32'(byte_sel), 32'd0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        do_reset();

        // Randomised traffic in segments of differing producer/consumer rates
        for (int seg = 0; seg < 12; seg++) begin
            int vr, sr;
            vr = (seg % 3 == 0) ? 80 : ((seg % 3 == 1) ? 10 : 35);
            sr = (seg % 3 == 0) ? 20 : 70;
            for (int c = 0; c < 250; c++) begin
                logic v, rx2, st, sp, bs;
                v   = ($urandom_range(99) < vr);
                rx2 = $urandom_range(1);
                bs  = ($urandom_range(99) < sr);
                st  = 0; sp = 0;
                if (m_ph == 0) begin
                    st = ($urandom_range(99) < 20);
                    sp = !st && ($urandom_range(99) < 5);
                end else if (m_ph == 3) begin
                    st = ($urandom_range(99) < 2);
                    sp = ($urandom_range(99) < 2);
                end
                cyc(v, rx2, st, sp, bs);
            end
            if (seg == 6) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
